// File: rtl/gt_serial_cmp.sv
// Sequential unsigned magnitude comparator: scans two bits per clock from the
// LSB pair up to the MSB pair and reports registered gt/eq/lt with a done pulse.
module gt_serial_cmp #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done_tick,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    localparam int PAIRS = W / 2;
    localparam int NW = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [NW-1:0] LAST = NW'(PAIRS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [W-1:0]  sa, sb;
    logic          g, e;
    logic          g_nx, e_nx;
    logic [NW-1:0] n;
    logic [1:0]    pa, pb;

    assign pa        = sa[1:0];
    assign pb        = sb[1:0];
    assign ready     = (state == S_IDLE);
    assign done_tick = (state == S_DONE);

    // A higher pair that differs overrides whatever the lower pairs decided.
    always_comb begin
        state_next = state;
        g_nx       = g;
        e_nx       = e;
        case (state)
            S_IDLE: if (start) state_next = S_OP;
            S_OP: begin
                if (pa > pb) begin
                    g_nx = 1'b1;
                    e_nx = 1'b0;
                end else if (pa < pb) begin
                    g_nx = 1'b0;
                    e_nx = 1'b0;
                end
                if (n == LAST) state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            sa    <= '0;
            sb    <= '0;
            g     <= 1'b0;
            e     <= 1'b0;
            n     <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa <= a;
                        sb <= b;
                        g  <= 1'b0;
                        e  <= 1'b1;
                        n  <= '0;
                    end
                end
                S_OP: begin
                    sa <= sa >> 2;
                    sb <= sb >> 2;
                    g  <= g_nx;
                    e  <= e_nx;
                    if (n == LAST) begin
                        gt <= g_nx;
                        eq <= e_nx;
                        lt <= ~g_nx & ~e_nx;
                    end else begin
                        n <= n + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/gt_serial_cmp.md
# gt_serial_cmp

Sequential magnitude comparator. It compares two W-bit unsigned operands two bits per clock, scanning from LSB to MSB. This is the reverse direction to the parallel MSB-first 4-bit comparator. The block sits beside the combinational compare units wherever area matters more than latency, and uses a start/done handshake toward the controlling FSM. Each compare yields registered greater, equal and less flags that hold until the next compare finishes.

## Interface
- W, 8, operand width in bits; must be even and ≥ 2.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only while ready=1.
- a  input  W  operand A, unsigned; sampled on the accepted start edge only.
- b  input  W  operand B, unsigned; sampled on the accepted start edge only.
- ready  output  1  high in idle; block accepts start.
- done_tick  output  1  one-cycle pulse; result flags are valid and newly updated.
- gt  output  1  registered result: A > B.
- eq  output  1  registered result: A == B.
- lt  output  1  registered result: A < B.

## Operation
- FSM states: idle, op, done.
- **idle**
  - ready=1.
  - On start=1: load shift registers sa←a and sb←b; set running flags g←0, e←1; set pair counter n←0; go to op.
- **op**
  - ready=0.
  - Each cycle, compare pa=sa[1:0] against pb=sb[1:0]:
    - pa>pb: g←1, e←0.
    - pa<pb: g←0, e←0.
    - pa==pb: g and e unchanged.
  - Shift sa and sb right by 2; n←n+1.
  - When n==W/2−1 (last pair, i.e. the MSB pair): load gt←g', eq←e', lt←~g'&~e'. Here g' and e' are the flag values after this cycle's update. Go to done.
- **done**
  - done_tick=1, ready=0; go to idle next cycle.
- Rule: a higher pair always overrides lower pairs; equal pairs preserve the lower-pair verdict. Exactly one of gt/eq/lt is high after any completed compare.
- start is ignored in op and done; no queuing.
- a and b may change freely after the accepted start edge.
- Counter width is clog2(W/2), minimum 1 bit; it never wraps within a compare.

## Timing
- Reset (synchronous): state=idle, ready=1, done_tick=0, gt=0, eq=0, lt=0, internal registers cleared.
- start accepted at rising edge E0 (ready=1, start=1):
  - op occupies cycles 1..W/2 after E0.
  - done_tick is high for exactly cycle W/2+1; gt/eq/lt update at the edge entering that cycle.
  - ready returns to 1 in cycle W/2+2.
- Latency from start to done_tick is W/2+1 cycles; for W=8 that is 5.
- Throughput: one compare per W/2+2 cycles. A start held high continuously is re-accepted in the first idle cycle.
- Result flags hold their value through idle and op until the next done cycle.
- Reset asserted mid-op or in done: the compare is aborted; all outputs take their reset values on that edge, and no done_tick is produced.
- start and reset asserted together: reset wins.

## Test plan
All scenarios use W=8.
- Reset, then idle for 3 cycles → ready=1, done_tick=0, gt=eq=lt=0 throughout.
- a=0xA5, b=0x5A, one-cycle start → done_tick exactly 5 cycles later; gt=1, eq=0, lt=0; ready high the following cycle.
- a=0x3C, b=0x3C → eq=1, gt=0, lt=0. Then a=0x01, b=0x02 → lt=1: the bit-0 win is overridden by the higher bit.
- a=0x80, b=0x7F → gt=1: only the final MSB pair decides. Then a=0x7F, b=0x80 → lt=1.
- Start a=0x10, b=0x20; pulse start with a=0xFF, b=0x00 two cycles later, and change a/b mid-op → second start ignored; result lt=1 from the original operands; one done_tick only.
- Start a=0xF0, b=0x0F; assert reset 2 cycles after acceptance → next edge: ready=1, gt=eq=lt=0, no done_tick. A subsequent start compares correctly.
